// File: rtl/mux_ctrl_pkg.sv
// Shared FSM encoding and select constants for the mux select sequencer.
package mux_ctrl_pkg;

   localparam int unsigned MAX_CODE = 10;
   localparam int unsigned ERR_SEL  = 9;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StDone,
      StErr
   } state_e;

endpackage

// File: rtl/sel_prog_regfile.sv
// Program store: one write port, one combinational read port.
// Synchronous reset clears every slot.
module sel_prog_regfile #(
   parameter  int unsigned DEPTH  = 8,
   parameter  int unsigned SEL_W  = 4,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [SEL_W-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [SEL_W-1:0]  rdata
);

   logic [SEL_W-1:0] slots_q [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            slots_q[i] <= '0;
         end
      end else if (we) begin
         slots_q[waddr] <= wdata;
      end
   end

   assign rdata = slots_q[raddr];

endmodule

// File: rtl/mux_select_sequencer.sv
// Steps an external selection mux through a programmed list of select codes,
// handshaking each step with the datapath via step_valid/step_ack.
module mux_select_sequencer #(
   parameter  int unsigned DEPTH    = 8,
   parameter  int unsigned SEL_W    = 4,
   parameter  int unsigned MAX_CODE = mux_ctrl_pkg::MAX_CODE,
   localparam int unsigned ADDR_W   = $clog2(DEPTH),
   localparam int unsigned LEN_W    = ADDR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [SEL_W-1:0]  cfg_data,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic              start,
   input  logic              step_ack,
   input  logic              abort,
   output logic [SEL_W-1:0]  select,
   output logic              step_valid,
   output logic [ADDR_W-1:0] step_idx,
   output logic              busy,
   output logic              done,
   output logic              error
);

   import mux_ctrl_pkg::*;

   state_e            state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [SEL_W-1:0]  select_q, select_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;

   logic [SEL_W-1:0]  slot_code;
   logic              len_ok;
   logic              code_bad;
   logic              last_step;

   sel_prog_regfile #(
      .DEPTH (DEPTH),
      .SEL_W (SEL_W)
   ) u_regfile (
      .clk   (clk),
      .rst   (rst),
      .we    (cfg_we && (state_q == StIdle)),
      .waddr (cfg_addr),
      .wdata (cfg_data),
      .raddr (idx_q),
      .rdata (slot_code)
   );

   assign len_ok    = (cfg_len != '0) && (cfg_len <= LEN_W'(DEPTH));
   assign code_bad  = 32'(slot_code) > MAX_CODE;
   assign last_step = ({1'b0, idx_q} == (len_q - LEN_W'(1)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         len_q    <= '0;
         idx_q    <= '0;
         select_q <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         idx_q    <= idx_d;
         select_q <= select_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         error_q  <= error_d;
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (len_ok) begin
                  len_d   = cfg_len;
                  idx_d   = '0;
                  state_d = StIssue;
               end else begin
                  state_d = StErr;
               end
            end
         end
         StIssue: begin
            if (abort)         state_d = StIdle;
            else if (code_bad) state_d = StErr;
            else               state_d = StWait;
         end
         StWait: begin
            if (abort) begin
               state_d = StIdle;
            end else if (step_ack) begin
               if (last_step) begin
                  state_d = StDone;
               end else begin
                  idx_d   = idx_q + ADDR_W'(1);
                  state_d = StIssue;
               end
            end
         end
         StDone:  state_d = StIdle;
         StErr:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output registers track the state being entered; step_valid rises one
   // cycle after select is loaded so the mux has settled before it is used.
   always_comb begin
      select_d = select_q;
      unique case (state_d)
         StIdle, StDone: select_d = '0;
         StErr:          select_d = SEL_W'(ERR_SEL);
         StWait:         if (state_q == StIssue) select_d = slot_code;
         default:        select_d = select_q;
      endcase
      valid_d = (state_q == StWait) && (state_d == StWait);
      busy_d  = (state_d == StIssue) || (state_d == StWait);
      done_d  = (state_d == StDone);
      error_d = (state_d == StErr);
   end

   assign select     = select_q;
   assign step_valid = valid_q;
   assign step_idx   = idx_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Directed bench for mux_select_sequencer: programs slots, runs sequences and
// checks outputs one time unit after each rising edge.
module tb_mux_select_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_we;
   logic [2:0] cfg_addr;
   logic [3:0] cfg_data;
   logic [3:0] cfg_len;
   logic       start;
   logic       step_ack;
   logic       abort;
   logic [3:0] select;
   logic       step_valid;
   logic [2:0] step_idx;
   logic       busy;
   logic       done;
   logic       error;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mux_select_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .cfg_len    (cfg_len),
      .start      (start),
      .step_ack   (step_ack),
      .abort      (abort),
      .select     (select),
      .step_valid (step_valid),
      .step_idx   (step_idx),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic write_slot(input logic [2:0] a, input logic [3:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      tick;
      cfg_we = 1'b0;
   endtask

   task automatic pulse_start(input logic [3:0] len);
      cfg_len = len; start = 1'b1;
      tick;
      start = 1'b0;
   endtask

   task automatic ack_step;
      step_ack = 1'b1;
      tick;
      step_ack = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick; tick;
      checks++;
      if ({select, step_idx, step_valid, busy, done, error} !== 11'd0) begin
         errors++;
         $display("FAIL reset_outputs: sel=%0d idx=%0d v=%b b=%b d=%b e=%b, required all 0",
                  select, step_idx, step_valid, busy, done, error);
      end
      rst = 1'b0;
      tick;
      checks++;
      if (busy !== 1'b0 || step_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: busy=%b valid=%b, required 0 0", busy, step_valid);
      end
   endtask

   task automatic test_basic_run;
      logic [3:0] exp_sel [3] = '{4'd3, 4'd7, 4'd10};
      write_slot(3'd0, 4'd3);
      write_slot(3'd1, 4'd7);
      write_slot(3'd2, 4'd10);
      pulse_start(4'd3);
      checks++;
      if (busy !== 1'b1 || step_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_issue: busy=%b valid=%b, required 1 0", busy, step_valid);
      end
      for (int i = 0; i < 3; i++) begin
         tick;
         checks++;
         if (step_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid step %0d: valid=%b, required 0", i, step_valid);
         end
         tick;
         checks++;
         if (step_valid !== 1'b1 || select !== exp_sel[i] || step_idx !== 3'(i)) begin
            errors++;
            $display("FAIL basic_step %0d: valid=%b sel=%0d idx=%0d, required 1 %0d %0d",
                     i, step_valid, select, step_idx, exp_sel[i], i);
         end
         tick;
         checks++;
         if (step_valid !== 1'b1 || select !== exp_sel[i] || step_idx !== 3'(i)) begin
            errors++;
            $display("FAIL basic_hold %0d: valid=%b sel=%0d idx=%0d, required 1 %0d %0d",
                     i, step_valid, select, step_idx, exp_sel[i], i);
         end
         ack_step;
         checks++;
         if (i < 2) begin
            if (done !== 1'b0 || busy !== 1'b1 || step_valid !== 1'b0) begin
               errors++;
               $display("FAIL basic_after_ack %0d: done=%b busy=%b valid=%b, required 0 1 0",
                        i, done, busy, step_valid);
            end
         end else begin
            if (done !== 1'b1 || busy !== 1'b0 || select !== 4'd0 || error !== 1'b0) begin
               errors++;
               $display("FAIL basic_done: done=%b busy=%b sel=%0d err=%b, required 1 0 0 0",
                        done, busy, select, error);
            end
         end
      end
      tick;
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL basic_done_pulse: done=%b, required 0", done);
      end
   endtask

   task automatic test_bad_length;
      logic [3:0] lens [2] = '{4'd0, 4'd9};
      for (int i = 0; i < 2; i++) begin
         pulse_start(lens[i]);
         checks++;
         if (error !== 1'b1 || busy !== 1'b0 || step_valid !== 1'b0 || select !== 4'd9) begin
            errors++;
            $display("FAIL badlen_%0d: err=%b busy=%b valid=%b sel=%0d, required 1 0 0 9",
                     lens[i], error, busy, step_valid, select);
         end
         tick;
         checks++;
         if (error !== 1'b0 || busy !== 1'b0 || select !== 4'd0) begin
            errors++;
            $display("FAIL badlen_pulse_%0d: err=%b busy=%b sel=%0d, required 0 0 0",
                     lens[i], error, busy, select);
         end
      end
      // Full-depth length is legal; abort it straight away.
      pulse_start(4'd8);
      checks++;
      if (busy !== 1'b1 || error !== 1'b0) begin
         errors++;
         $display("FAIL len_max: busy=%b err=%b, required 1 0", busy, error);
      end
      abort = 1'b1; tick; abort = 1'b0;
   endtask

   task automatic test_bad_code;
      write_slot(3'd1, 4'd12);
      pulse_start(4'd2);
      tick; tick;
      checks++;
      if (step_valid !== 1'b1 || select !== 4'd3) begin
         errors++;
         $display("FAIL badcode_step0: valid=%b sel=%0d, required 1 3", step_valid, select);
      end
      ack_step;
      tick;
      checks++;
      if (error !== 1'b1 || select !== 4'd9 || done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL badcode_err: err=%b sel=%0d done=%b busy=%b, required 1 9 0 0",
                  error, select, done, busy);
      end
      tick;
      checks++;
      if (error !== 1'b0 || done !== 1'b0 || select !== 4'd0) begin
         errors++;
         $display("FAIL badcode_pulse: err=%b done=%b sel=%0d, required 0 0 0",
                  error, done, select);
      end
      write_slot(3'd1, 4'd7);
   endtask

   task automatic test_abort;
      pulse_start(4'd3);
      tick; tick;
      ack_step;
      tick; tick;
      checks++;
      if (step_valid !== 1'b1 || step_idx !== 3'd1 || select !== 4'd7) begin
         errors++;
         $display("FAIL abort_step1: valid=%b idx=%0d sel=%0d, required 1 1 7",
                  step_valid, step_idx, select);
      end
      abort = 1'b1; step_ack = 1'b1;
      tick;
      abort = 1'b0; step_ack = 1'b0;
      checks++;
      if (busy !== 1'b0 || step_valid !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: busy=%b valid=%b done=%b err=%b, required 0 0 0 0",
                  busy, step_valid, done, error);
      end
      tick;
      checks++;
      if (done !== 1'b0 || error !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_quiet: done=%b err=%b busy=%b, required 0 0 0", done, error, busy);
      end
      pulse_start(4'd3);
      tick; tick;
      checks++;
      if (step_valid !== 1'b1 || step_idx !== 3'd0 || select !== 4'd3) begin
         errors++;
         $display("FAIL abort_replay: valid=%b idx=%0d sel=%0d, required 1 0 3",
                  step_valid, step_idx, select);
      end
      abort = 1'b1; tick; abort = 1'b0;
   endtask

   task automatic test_cfg_while_busy;
      pulse_start(4'd1);
      cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 4'd5;
      tick;
      cfg_we = 1'b0;
      // A start during the run must be ignored, even with an illegal length.
      pulse_start(4'd0);
      checks++;
      if (error !== 1'b0 || step_valid !== 1'b1) begin
         errors++;
         $display("FAIL start_ignored: err=%b valid=%b, required 0 1", error, step_valid);
      end
      ack_step;
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL cfgbusy_done1: done=%b, required 1", done);
      end
      tick;
      step_ack = 1'b1; tick; step_ack = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
         errors++;
         $display("FAIL idle_ack_ignored: busy=%b done=%b err=%b, required 0 0 0",
                  busy, done, error);
      end
      pulse_start(4'd1);
      tick; tick;
      checks++;
      if (step_valid !== 1'b1 || select !== 4'd3) begin
         errors++;
         $display("FAIL cfgbusy_slot0: valid=%b sel=%0d, required 1 3", step_valid, select);
      end
      ack_step;
      tick;
   endtask

   task automatic test_reset_midrun;
      pulse_start(4'd3);
      tick; tick;
      rst = 1'b1;
      tick;
      checks++;
      if ({select, step_idx, step_valid, busy, done, error} !== 11'd0) begin
         errors++;
         $display("FAIL midrun_reset: sel=%0d idx=%0d v=%b b=%b d=%b e=%b, required all 0",
                  select, step_idx, step_valid, busy, done, error);
      end
      rst = 1'b0;
      pulse_start(4'd1);
      tick; tick;
      checks++;
      if (step_valid !== 1'b1 || select !== 4'd0) begin
         errors++;
         $display("FAIL midrun_slot_cleared: valid=%b sel=%0d, required 1 0", step_valid, select);
      end
      ack_step;
      checks++;
      if (done !== 1'b1 || error !== 1'b0) begin
         errors++;
         $display("FAIL midrun_done: done=%b err=%b, required 1 0", done, error);
      end
      tick;
   endtask

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_len = '0;
      start = 1'b0; step_ack = 1'b0; abort = 1'b0;
      test_reset;
      test_basic_run;
      test_bad_length;
      test_bad_code;
      test_abort;
      test_cfg_while_busy;
      test_reset_midrun;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
